// File: rtl/id_stage_iq_pkg.sv
// Shared decode definitions for the queued decode stage: opcodes, ALU codes,
// control word, and the cu / eximm decode helpers.
package id_stage_iq_pkg;

   localparam logic [6:0] Utype_LUI   = 7'b0110111;
   localparam logic [6:0] Utype_AUIPC = 7'b0010111;
   localparam logic [6:0] Jtype_J     = 7'b1101111;
   localparam logic [6:0] Itype_JALR  = 7'b1100111;
   localparam logic [6:0] Btype       = 7'b1100011;
   localparam logic [6:0] Itype_L     = 7'b0000011;
   localparam logic [6:0] Stype       = 7'b0100011;
   localparam logic [6:0] Itype       = 7'b0010011;
   localparam logic [6:0] Rtype       = 7'b0110011;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_LUI, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU,
      ALU_BGEU, ALU_JAL
   } alu_e;

   typedef struct packed {
      logic reg1_re;
      logic reg2_re;
      logic reg_we;
      logic btype;
      logic imm_sel;
      alu_e alu;
   } ctrl_t;

   // A queue entry carries the fetch PC alongside the raw instruction word.
   function automatic int iq_entry_w(input int xlen);
      return xlen + 32;
   endfunction

   function automatic alu_e alu_of(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic ctrl_t cu(input logic [31:0] inst);
      ctrl_t c;
      c.reg1_re = 1'b0;
      c.reg2_re = 1'b0;
      c.reg_we  = 1'b0;
      c.btype   = 1'b0;
      c.imm_sel = 1'b0;
      c.alu     = ALU_ADD;
      case (inst[6:0])
         Rtype:   begin c.reg1_re = 1'b1; c.reg2_re = 1'b1; c.reg_we = 1'b1;
                        c.alu = alu_of(inst[14:12], inst[30]); end
         // Only the shift-right encoding uses bit 30 on immediates.
         Itype:   begin c.reg1_re = 1'b1; c.reg_we = 1'b1; c.imm_sel = 1'b1;
                        c.alu = alu_of(inst[14:12], (inst[14:12] == 3'b101) && inst[30]); end
         Itype_L: begin c.reg1_re = 1'b1; c.reg_we = 1'b1; c.imm_sel = 1'b1; end
         Stype:   begin c.reg1_re = 1'b1; c.reg2_re = 1'b1; c.imm_sel = 1'b1; end
         Btype:   begin
            c.reg1_re = 1'b1; c.reg2_re = 1'b1; c.btype = 1'b1;
            case (inst[14:12])
               3'b000:  c.alu = ALU_BEQ;
               3'b001:  c.alu = ALU_BNE;
               3'b100:  c.alu = ALU_BLT;
               3'b101:  c.alu = ALU_BGE;
               3'b110:  c.alu = ALU_BLTU;
               default: c.alu = ALU_BGEU;
            endcase
         end
         Utype_LUI:   begin c.reg_we = 1'b1; c.imm_sel = 1'b1; c.alu = ALU_LUI; end
         Utype_AUIPC: begin c.reg_we = 1'b1; c.imm_sel = 1'b1; end
         Jtype_J:     begin c.reg_we = 1'b1; c.imm_sel = 1'b1; c.alu = ALU_JAL; end
         Itype_JALR:  begin c.reg1_re = 1'b1; c.reg_we = 1'b1; c.imm_sel = 1'b1; c.alu = ALU_JAL; end
         default: ;
      endcase
      return c;
   endfunction

   function automatic logic [31:0] eximm(input logic [31:0] inst);
      case (inst[6:0])
         Itype, Itype_L, Itype_JALR: return {{20{inst[31]}}, inst[31:20]};
         Stype:                      return {{20{inst[31]}}, inst[31:25], inst[11:7]};
         Btype:                      return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         Utype_LUI, Utype_AUIPC:     return {inst[31:12], 12'b0};
         Jtype_J:                    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default:                    return 32'b0;
      endcase
   endfunction

endpackage

// File: rtl/id_stage_iq_if.sv
// Fetch-to-decode beat handshake.
interface id_stage_iq_if #(parameter int XLEN = 32);
   logic            if_valid_i;
   logic            if_ready_o;
   logic [XLEN-1:0] if_pc_i;
   logic [31:0]     if_inst_i;

   modport master (output if_valid_i, if_pc_i, if_inst_i, input if_ready_o);
   modport slave  (input if_valid_i, if_pc_i, if_inst_i, output if_ready_o);
endinterface

// File: rtl/id_stage_iq_inst_queue.sv
// Power-of-two circular FIFO; clear wins over push/pop in the same cycle.
module id_stage_iq_inst_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [PW-1:0]               rd_ptr, wr_ptr;
   logic [CW-1:0]               count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];
endmodule

// File: rtl/id_stage_iq.sv
// Queued RV32I decode stage: fetch beats land in a FIFO, the head is decoded
// combinationally and issued to id_ex; JAL and EX redirects flush and drop stale beats.
module id_stage_iq
   import id_stage_iq_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int IQ_DEPTH   = 4,
   parameter int DROP_BEATS = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   id_stage_iq_if.slave    fetch,
   output logic [4:0]      id_reg1_raddr_o,
   output logic [4:0]      id_reg2_raddr_o,
   input  logic [XLEN-1:0] regs_reg1_rdata_i,
   input  logic [XLEN-1:0] regs_reg2_rdata_i,
   output logic            id_reg1_re_o,
   output logic            id_reg2_re_o,
   input  logic            dhnf_harzard_sel1_i,
   input  logic            dhnf_harzard_sel2_i,
   input  logic [XLEN-1:0] dhnf_forward_data1_i,
   input  logic [XLEN-1:0] dhnf_forward_data2_i,
   input  logic            dhnf_stall_i,
   input  logic            ex_flush_i,
   input  logic            ex_ready_i,
   output logic            id_valid_o,
   output logic [XLEN-1:0] id_pc_o,
   output logic [XLEN-1:0] id_op_a_o,
   output logic [XLEN-1:0] id_op_b_o,
   output logic [XLEN-1:0] id_imm_o,
   output logic [4:0]      id_reg_waddr_o,
   output logic            id_reg_we_o,
   output logic [4:0]      id_ALUctrl_o,
   output logic            id_btype_o,
   output logic [XLEN-1:0] id_next_pc_o,
   output logic            id_jump_o,
   output logic [XLEN-1:0] id_jump_target_o
);
   localparam int EW = iq_entry_w(XLEN);
   localparam int DW = (DROP_BEATS > 0) ? $clog2(DROP_BEATS + 1) : 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
   } iq_entry_t;

   iq_entry_t       din, head;
   logic            full, empty, accept, push, issue, clear;
   logic [DW-1:0]   drop_cnt;
   ctrl_t           ctrl;
   logic [XLEN-1:0] imm;

   assign din    = '{pc: fetch.if_pc_i, inst: fetch.if_inst_i};
   assign accept = fetch.if_valid_i && fetch.if_ready_o;
   assign push   = accept && (drop_cnt == '0) && !ex_flush_i;
   assign issue  = id_valid_o && ex_ready_i && !dhnf_stall_i;
   assign clear  = ex_flush_i || id_jump_o;

   assign fetch.if_ready_o = !full;
   assign id_valid_o       = !empty && !ex_flush_i;
   assign id_jump_o        = issue && (head.inst[6:0] == Jtype_J);

   id_stage_iq_inst_queue #(.DEPTH(IQ_DEPTH), .WIDTH(EW)) u_iq (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (issue),
      .clear (clear),
      .din   (din),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   // Beats already in flight from the old path are accepted then thrown away.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         drop_cnt <= '0;
      else if (clear)                     drop_cnt <= DW'(DROP_BEATS);
      else if (accept && drop_cnt != '0)  drop_cnt <= drop_cnt - DW'(1);
   end

   always_comb begin
      ctrl = cu(head.inst);
      imm  = XLEN'($signed(eximm(head.inst)));
   end

   assign id_pc_o          = head.pc;
   assign id_imm_o         = imm;
   assign id_reg1_raddr_o  = head.inst[19:15];
   assign id_reg2_raddr_o  = head.inst[24:20];
   assign id_reg_waddr_o   = head.inst[11:7];
   assign id_ALUctrl_o     = ctrl.alu;
   assign id_op_a_o        = dhnf_harzard_sel1_i ? dhnf_forward_data1_i : regs_reg1_rdata_i;
   assign id_op_b_o        = dhnf_harzard_sel2_i ? dhnf_forward_data2_i :
                             ctrl.imm_sel        ? imm : regs_reg2_rdata_i;
   assign id_next_pc_o     = head.pc + imm;
   assign id_jump_target_o = head.pc + imm;

   assign id_reg_we_o  = id_valid_o && ctrl.reg_we;
   assign id_btype_o   = id_valid_o && ctrl.btype;
   assign id_reg1_re_o = id_valid_o && ctrl.reg1_re;
   assign id_reg2_re_o = id_valid_o && ctrl.reg2_re;
endmodule

// File: tb/tb_id_stage_iq.sv
// Directed bench for id_stage_iq: queueing, backpressure, JAL/flush drop, stall, reset.
module tb_id_stage_iq;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [XLEN-1:0] regs1, regs2, fwd1, fwd2;
   logic            sel1, sel2, stall, flush, ex_ready;
   logic [4:0]      raddr1, raddr2, waddr, aluctrl;
   logic            re1, re2, valid, we, btype, jump;
   logic [XLEN-1:0] pc, op_a, op_b, imm, next_pc, jtgt;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   id_stage_iq_if #(.XLEN(XLEN)) fif ();

   id_stage_iq #(.XLEN(XLEN), .IQ_DEPTH(4), .DROP_BEATS(1)) u_dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .fetch                (fif),
      .id_reg1_raddr_o      (raddr1),
      .id_reg2_raddr_o      (raddr2),
      .regs_reg1_rdata_i    (regs1),
      .regs_reg2_rdata_i    (regs2),
      .id_reg1_re_o         (re1),
      .id_reg2_re_o         (re2),
      .dhnf_harzard_sel1_i  (sel1),
      .dhnf_harzard_sel2_i  (sel2),
      .dhnf_forward_data1_i (fwd1),
      .dhnf_forward_data2_i (fwd2),
      .dhnf_stall_i         (stall),
      .ex_flush_i           (flush),
      .ex_ready_i           (ex_ready),
      .id_valid_o           (valid),
      .id_pc_o              (pc),
      .id_op_a_o            (op_a),
      .id_op_b_o            (op_b),
      .id_imm_o             (imm),
      .id_reg_waddr_o       (waddr),
      .id_reg_we_o          (we),
      .id_ALUctrl_o         (aluctrl),
      .id_btype_o           (btype),
      .id_next_pc_o         (next_pc),
      .id_jump_o            (jump),
      .id_jump_target_o     (jtgt)
   );

   // addi xN, x0, 1 for N = 1..5
   logic [31:0] addi_rd [5] = '{32'h00100093, 32'h00100113, 32'h00100193,
                                32'h00100213, 32'h00100293};
   localparam logic [31:0] JAL_X1_20 = 32'h020000EF;
   localparam logic [31:0] ADD_567   = 32'h007302B3;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic beat(input logic v, input logic [31:0] bpc, input logic [31:0] inst);
      fif.if_valid_i = v;
      fif.if_pc_i    = bpc;
      fif.if_inst_i  = inst;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; regs1 = '0; regs2 = '0; fwd1 = '0; fwd2 = '0;
      sel1 = 1'b0; sel2 = 1'b0; stall = 1'b0; flush = 1'b0; ex_ready = 1'b0;
      beat(1'b0, 32'h0, 32'h0);
      #2;
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_ready", 32'(fif.if_ready_o), 32'd1);
      chk("rst_jump", 32'(jump), 32'd0);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_re1", 32'(re1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      nxt();

      // 1: streaming addi, one cycle from accept to head
      ex_ready = 1'b1; regs1 = 32'h55; regs2 = 32'h77;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) beat(1'b1, 32'(i * 4), addi_rd[i]);
         else       beat(1'b0, 32'h0, 32'h0);
         mid();
         if (i == 0) chk("t1_valid_first", 32'(valid), 32'd0);
         else begin
            chk("t1_valid", 32'(valid), 32'd1);
            chk("t1_pc", pc, 32'((i - 1) * 4));
            chk("t1_waddr", 32'(waddr), 32'(i));
            chk("t1_op_b", op_b, 32'd1);
         end
         if (i == 1) begin
            chk("t1_op_a", op_a, 32'h55);
            chk("t1_alu", 32'(aluctrl), 32'd0);
            chk("t1_re1", 32'(re1), 32'd1);
            chk("t1_re2", 32'(re2), 32'd0);
         end
         nxt();
      end
      mid(); chk("t1_drained", 32'(valid), 32'd0); nxt();

      // 2: backpressure with 5 beats into a 4-deep queue
      ex_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         beat(1'b1, 32'h40 + 32'(k * 4), addi_rd[k]);
         mid(); chk("t2_ready_fill", 32'(fif.if_ready_o), 32'd1); nxt();
      end
      beat(1'b1, 32'h50, addi_rd[4]);
      mid();
      chk("t2_ready_full", 32'(fif.if_ready_o), 32'd0);
      chk("t2_head", pc, 32'h40);
      nxt();
      mid(); chk("t2_hold_ready", 32'(fif.if_ready_o), 32'd0); chk("t2_hold_pc", pc, 32'h40); nxt();
      ex_ready = 1'b1;
      mid(); chk("t2_no_push_full", 32'(fif.if_ready_o), 32'd0); chk("t2_pc0", pc, 32'h40); nxt();
      mid(); chk("t2_ready_again", 32'(fif.if_ready_o), 32'd1); chk("t2_pc1", pc, 32'h44); nxt();
      beat(1'b0, 32'h0, 32'h0);
      for (int k = 2; k < 5; k++) begin
         mid(); chk("t2_drain_valid", 32'(valid), 32'd1); chk("t2_drain_pc", pc, 32'h40 + 32'(k * 4)); nxt();
      end
      mid(); chk("t2_empty", 32'(valid), 32'd0); nxt();

      // 3: JAL redirect with two younger entries, one beat dropped after
      ex_ready = 1'b0;
      beat(1'b1, 32'h100, JAL_X1_20);   nxt();
      beat(1'b1, 32'h104, addi_rd[1]);  nxt();
      beat(1'b1, 32'h108, addi_rd[2]);  nxt();
      beat(1'b0, 32'h0, 32'h0); ex_ready = 1'b1;
      mid();
      chk("t3_jump", 32'(jump), 32'd1);
      chk("t3_target", jtgt, 32'h120);
      chk("t3_imm", imm, 32'h20);
      chk("t3_we", 32'(we), 32'd1);
      chk("t3_waddr", 32'(waddr), 32'd1);
      nxt();
      mid(); chk("t3_cleared", 32'(valid), 32'd0); chk("t3_jump_once", 32'(jump), 32'd0); nxt();
      beat(1'b1, 32'h200, addi_rd[0]);
      mid(); chk("t3_drop_cycle", 32'(valid), 32'd0); nxt();
      beat(1'b1, 32'h204, addi_rd[1]);
      mid(); chk("t3_dropped", 32'(valid), 32'd0); nxt();
      beat(1'b0, 32'h0, 32'h0);
      mid(); chk("t3_stored_valid", 32'(valid), 32'd1); chk("t3_stored_pc", pc, 32'h204); nxt();
      mid(); chk("t3_done", 32'(valid), 32'd0); nxt();

      // 4: ex_flush with a JAL at the head
      ex_ready = 1'b0;
      beat(1'b1, 32'h300, JAL_X1_20);  nxt();
      beat(1'b1, 32'h304, addi_rd[1]); nxt();
      beat(1'b1, 32'h308, addi_rd[2]); ex_ready = 1'b1; flush = 1'b1;
      mid();
      chk("t4_valid", 32'(valid), 32'd0);
      chk("t4_jump", 32'(jump), 32'd0);
      chk("t4_we", 32'(we), 32'd0);
      nxt();
      flush = 1'b0; beat(1'b1, 32'h400, addi_rd[3]);
      mid(); chk("t4_cleared", 32'(valid), 32'd0); nxt();
      beat(1'b1, 32'h404, addi_rd[0]);
      mid(); chk("t4_dropped", 32'(valid), 32'd0); nxt();
      beat(1'b0, 32'h0, 32'h0);
      mid(); chk("t4_stored_valid", 32'(valid), 32'd1); chk("t4_stored_pc", pc, 32'h404); nxt();
      mid(); chk("t4_done", 32'(valid), 32'd0); nxt();

      // 5: load-use stall with forwarded rs2
      regs1 = 32'h1111; regs2 = 32'h2222; sel2 = 1'b1; fwd2 = 32'hDEAD;
      beat(1'b1, 32'h500, ADD_567);
      mid(); chk("t5_pre", 32'(valid), 32'd0); nxt();
      beat(1'b0, 32'h0, 32'h0); stall = 1'b1;
      for (int s = 0; s < 3; s++) begin
         mid();
         chk("t5_valid", 32'(valid), 32'd1);
         chk("t5_pc", pc, 32'h500);
         chk("t5_op_b", op_b, 32'hDEAD);
         if (s == 0) begin
            chk("t5_op_a", op_a, 32'h1111);
            chk("t5_raddr1", 32'(raddr1), 32'd6);
            chk("t5_raddr2", 32'(raddr2), 32'd7);
            chk("t5_waddr", 32'(waddr), 32'd5);
            chk("t5_re2", 32'(re2), 32'd1);
         end
         nxt();
      end
      stall = 1'b0; sel2 = 1'b0; sel1 = 1'b1; fwd1 = 32'hBEEF;
      mid();
      chk("t5_issue_valid", 32'(valid), 32'd1);
      chk("t5_issue_pc", pc, 32'h500);
      chk("t5_op_b_regs", op_b, 32'h2222);
      chk("t5_op_a_fwd", op_a, 32'hBEEF);
      nxt();
      sel1 = 1'b0;
      mid(); chk("t5_popped", 32'(valid), 32'd0); nxt();

      // 6: reset with three entries queued
      ex_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         beat(1'b1, 32'h600 + 32'(k * 4), addi_rd[k]); nxt();
      end
      beat(1'b0, 32'h0, 32'h0);
      mid(); chk("t6_queued", 32'(valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(valid), 32'd0);
      chk("t6_rst_ready", 32'(fif.if_ready_o), 32'd1);
      nxt();
      @(negedge clk); rst_n = 1'b1;
      nxt();
      ex_ready = 1'b1;
      beat(1'b1, 32'h700, addi_rd[0]);
      mid(); chk("t6_post_valid", 32'(valid), 32'd0); chk("t6_post_ready", 32'(fif.if_ready_o), 32'd1); nxt();
      beat(1'b0, 32'h0, 32'h0);
      mid(); chk("t6_no_drop_valid", 32'(valid), 32'd1); chk("t6_no_drop_pc", pc, 32'h700); nxt();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/id_stage_iq.md
Name: id_stage_iq

Overview:
- Parametrised decode stage for the 5-stage RV32I pipeline. Sits between fetch and the id_ex register.
- Adds an IQ_DEPTH-entry instruction queue and valid/ready handshakes on both sides.
- Supports load-use stall hold, EX-redirect flush, and JAL redirect issued from decode.
- Drops a configurable number of stale fetch beats after any redirect.

Parameters:
- XLEN, 32, datapath width of PC, operands, immediates.
- IQ_DEPTH, 4, instruction-queue entries; power of two, ≥2.
- DROP_BEATS, 1, accepted fetch beats discarded after a flush or jump; 0 disables dropping.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- if_valid_i  in  1  fetch beat valid.
- if_ready_o  out  1  queue can accept a beat.
- if_pc_i  in  XLEN  PC of the fetch beat.
- if_inst_i  in  32  instruction word.
- id_reg1_raddr_o / id_reg2_raddr_o  out  5  rs1/rs2 of the head entry, to regs and dhnf.
- regs_reg1_rdata_i / regs_reg2_rdata_i  in  XLEN  register file read data.
- id_reg1_re_o / id_reg2_re_o  out  1  rs1/rs2 are actually read; gated by id_valid_o.
- dhnf_harzard_sel1_i / dhnf_harzard_sel2_i  in  1  forwarding select per operand.
- dhnf_forward_data1_i / dhnf_forward_data2_i  in  XLEN  forwarded data.
- dhnf_stall_i  in  1  load-use stall; hold the head entry.
- ex_flush_i  in  1  EX branch-taken redirect.
- ex_ready_i  in  1  id_ex register can accept.
- id_valid_o  out  1  head entry valid for issue.
- id_pc_o  out  XLEN  head PC.
- id_op_a_o / id_op_b_o  out  XLEN  operands, with forwarding applied.
- id_imm_o  out  XLEN  sign-extended immediate.
- id_reg_waddr_o  out  5  rd.
- id_reg_we_o  out  1  writes rd; gated by id_valid_o.
- id_ALUctrl_o  out  5  ALU control.
- id_btype_o  out  1  B-type; gated.
- id_next_pc_o  out  XLEN  id_pc_o + id_imm_o (B-type target).
- id_jump_o  out  1  JAL issued this cycle.
- id_jump_target_o  out  XLEN  id_pc_o + id_imm_o.

Behaviour:
- **Queue:** circular buffer with rd_ptr, wr_ptr and count. count width is clog2(IQ_DEPTH+1).
  - if_ready_o = (count != IQ_DEPTH). No same-cycle enqueue-on-full.
  - Enqueue when if_valid_i && if_ready_o && drop_cnt==0 && !ex_flush_i.
  - Accepted beats with drop_cnt!=0 are consumed: decrement drop_cnt, do not store.
- **Issue:** id_valid_o = (count!=0) && !ex_flush_i. issue = id_valid_o && ex_ready_i && !dhnf_stall_i.
  - issue pops the head. Simultaneous enqueue and pop adjusts count by 0.
- **Latency:** no bypass. A beat accepted in cycle N is at the head at the earliest in cycle N+1.
- **Decode:** combinational from the head entry, reusing the existing cu and eximm blocks.
  - id_op_b_o priority: forward select, then immediate (cu op_b select), then regs rdata.
  - id_op_a_o: forward select, else regs rdata.
  - All arithmetic is modulo 2^XLEN.
- **JAL:** when issue && head opcode == Jtype_J, assert id_jump_o for that cycle. At the clock edge:
  - clear the queue (pointers and count to 0);
  - load drop_cnt = DROP_BEATS.
  - The JAL itself is issued with reg_we for the link write.
- **ex_flush_i:** suppresses issue and enqueue that cycle and forces id_jump_o=0. At the edge:
  - clear the queue;
  - load drop_cnt = DROP_BEATS.
  - ex_flush_i takes priority over a simultaneous JAL issue and over drop decrement.
- **Stall:** dhnf_stall_i or !ex_ready_i holds the head and all outputs stable. Enqueue continues until full.
- **Gating:** id_reg_we_o, id_btype_o, id_reg1_re_o, id_reg2_re_o and id_jump_o are 0 whenever id_valid_o=0. Data outputs are don't-care when invalid.
- **Reset (async, rst_n low):**
  - count, pointers and drop_cnt go to 0; queue contents go to 0 (NOP-equivalent).
  - Outputs: id_valid_o=0, id_jump_o=0, if_ready_o=1, all gated controls 0.
- **Reset mid-operation:** all in-flight entries are lost. There is no pending drop after reset release.

Decomposition:
- Opcode constants (Btype, Jtype_J, Itype, etc.) and ALU control codes stay in the shared define.v.
- Add IQ entry width (XLEN+32) as a define.
- Sub-module inst_queue: parametrised FIFO with depth, width, push, pop, clear, full, empty and head data.
- Decode glue, drop counter and gating stay in id_stage_iq.

Test Plan:
1. Reset, then push 4 beats (pc 0x0..0xC, addi x1..x4 imm 1) with ex_ready_i=1 → id_valid_o first high the cycle after the first accept; issues in order; id_op_b_o=1; id_reg_waddr_o=1,2,3,4.
2. ex_ready_i=0, push 5 beats with IQ_DEPTH=4 → if_ready_o=0 after the 4th accept; 5th held; releasing ex_ready_i drains in order and accepts the 5th one cycle later.
3. JAL x1,+0x20 at pc 0x100 with 2 younger entries queued, DROP_BEATS=1 → id_jump_o=1 with target 0x120 for one cycle; queue empty next cycle; the next accepted beat is discarded, the one after is stored.
4. ex_flush_i in the same cycle as a JAL at the head → id_jump_o=0, id_valid_o=0, queue cleared, drop_cnt=DROP_BEATS.
5. dhnf_stall_i high 3 cycles with a head add x5,x6,x7 and dhnf_harzard_sel2_i=1, data 0xDEAD → outputs stable for 3 cycles; id_op_b_o=0xDEAD; issue on the 4th cycle.
6. Assert rst_n=0 mid-stream with 3 entries queued → id_valid_o=0 immediately; after release if_ready_o=1 and count 0.
